transposed_fir_hls_mul_pipe: RTL and testbench
==============================================

Name: transposed_fir_hls_mul_pipe

Overview:
Parametrised, pipelined signed-by-signed/unsigned multiplier for the transposed FIR tap datapath; the successor of the fixed 16s x 7ns combinational multiplier.
- Adds configurable operand signedness, a Q-format output shift, NUM_STAGE register stages and valid/ready flow control with clock-enable.
- Sits between the coefficient/sample fetch and the tap adder chain.

Parameters:
ID, 1, instance tag; no functional effect.
NUM_STAGE, 2, pipeline depth in registered stages; legal range 1..8.
din0_WIDTH, 16, sample operand width; always signed.
din1_WIDTH, 7, coefficient operand width.
DIN1_SIGNED, 0, 1 = din1 is two's complement; 0 = din1 is zero-extended by one bit.
dout_WIDTH, 23, result width.
SHIFT, 0, arithmetic right shift applied to the full product; range 0..din0_WIDTH+din1_WIDTH.

Ports:
ap_clk  in  1  clock; all registers rise-edge.
ap_rst_n  in  1  asynchronous, active-low reset.
ce  in  1  clock enable; low freezes all state.
in_valid  in  1  din0/din1 qualify.
in_ready  out  1  block accepts when in_valid && in_ready.
din0  in  din0_WIDTH  signed sample.
din1  in  din1_WIDTH  coefficient, signedness per DIN1_SIGNED.
out_valid  out  1  dout qualify.
out_ready  in  1  downstream accepts.
dout  out  dout_WIDTH  result.

Behaviour:
- Reset: ap_rst_n low immediately clears all stage valid bits, so out_valid=0. dout and data registers clear to 0. Reset is released synchronously to the design by the system; no internal synchroniser.
- Advance enable: adv = ce && (!out_valid || out_ready). All stages shift on adv, including empty (bubble) stages. in_ready = adv (combinational).
- Accept/latency: a beat accepted at edge k appears on dout with out_valid=1 after exactly NUM_STAGE advancing edges. With continuous adv, throughput is 1 beat/cycle.
- Stall: when out_valid=1 and out_ready=0, or ce=0:
  - dout and out_valid hold stable.
  - in_ready=0.
  - No beat is lost or duplicated.
- Arithmetic:
  - P = signed(din0) * ext(din1), full width W = din0_WIDTH+din1_WIDTH+1.
  - ext is sign-extend when DIN1_SIGNED=1, zero-extend otherwise.
  - S = P >>> SHIFT (floor, no rounding).
  - dout = S[dout_WIDTH-1:0] (wrap), unless the optional feature is enabled. If dout_WIDTH > W, S is sign-extended.
- Placement: the multiply may be retimed across stages freely; only total latency and results are specified.
- Simultaneous out_ready and in_valid: the output beat retires and the new beat enters on the same edge.
- Reset mid-operation: in-flight beats are discarded. The first post-reset beat behaves normally.
- Pipeline flush: no sideband is provided. Upstream drains by deasserting in_valid for NUM_STAGE advancing cycles.

Optional Feature:
FIR_MUL_PIPE_SAT_EN
- Defined: if S lies outside the signed dout_WIDTH range, dout is clamped to +(2^(dout_WIDTH-1)-1) or -2^(dout_WIDTH-1). An extra output port sat_flag (1 bit) is registered alongside dout, is valid with out_valid, and resets to 0.
- Undefined: wrap truncation, and no sat_flag port.

Decomposition:
- Package fir_mul_pkg:
  - function prod_width(din0_w, din1_w) returning the full product width W.
  - Saturation min/max constant functions.
  - typedef of the stage control struct {valid, sat}.
- One sub-module, fir_mul_pipe_stage: a single valid+data register with adv enable and async active-low reset. It is instantiated NUM_STAGE times via generate.

Test Plan:
- Latency, defaults: din0=3, din1=5, single beat, out_ready=1 -> dout=15, out_valid exactly 2 cycles after accept; out_valid=0 otherwise.
- Extremes, defaults: din0=-32768, din1=127 -> dout=-4161536. Back-to-back stream of 100 random beats -> matches the reference model in order, 1 beat/cycle.
- Signedness: din0=100, din1=7'h7F -> dout=12700 with DIN1_SIGNED=0; dout=-100 with DIN1_SIGNED=1. SHIFT=1, din0=-3, din1=1 -> dout=-2.
- Backpressure/ce: stream 8 beats, hold out_ready=0 for 3 cycles, then ce=0 for 2 cycles -> dout/out_valid stable, in_ready=0 throughout, all 8 results delivered once, in order.
- Saturation: dout_WIDTH=16, din0=1000, din1=100 -> with FIR_MUL_PIPE_SAT_EN: dout=32767, sat_flag=1; without it: dout=-31072.
- Reset mid-stream: assert ap_rst_n=0 with 2 beats in flight -> out_valid=0 immediately without a clock edge. After release, beat 7*7 -> dout=49 after NUM_STAGE cycles, and no stale beats appear.

Source files
------------

// File: rtl/transposed_fir_hls_mul_pipe_pkg.sv
// rtl/transposed_fir_hls_mul_pipe_pkg.sv - shared types and width/saturation helpers for the FIR tap multiplier
package fir_mul_pkg;

    typedef struct packed {
        logic valid;
        logic sat;
    } stage_ctrl_t;

    function automatic int prod_width(input int din0_w, input int din1_w);
        // The extra bit absorbs the zero-extension of an unsigned coefficient.
        return din0_w + din1_w + 1;
    endfunction

    function automatic logic [63:0] sat_max(input int w);
        return (64'd1 << (w - 1)) - 64'd1;
    endfunction

    function automatic logic [63:0] sat_min(input int w);
        return ~64'd0 << (w - 1);
    endfunction

endpackage

// File: rtl/transposed_fir_hls_mul_pipe_if.sv
// rtl/transposed_fir_hls_mul_pipe_if.sv - operand/result handshake bundle; sat_flag exists only with FIR_MUL_PIPE_SAT_EN
interface transposed_fir_hls_mul_pipe_if #(
    parameter int din0_WIDTH = 16,
    parameter int din1_WIDTH = 7,
    parameter int dout_WIDTH = 23
) ();
    logic                  in_valid;
    logic                  in_ready;
    logic [din0_WIDTH-1:0] din0;
    logic [din1_WIDTH-1:0] din1;
    logic                  out_valid;
    logic                  out_ready;
    logic [dout_WIDTH-1:0] dout;

`ifdef FIR_MUL_PIPE_SAT_EN
    logic                  sat_flag;

    modport slave (
        input  in_valid, din0, din1, out_ready,
        output in_ready, out_valid, dout, sat_flag
    );
    modport master (
        output in_valid, din0, din1, out_ready,
        input  in_ready, out_valid, dout, sat_flag
    );
`else
    modport slave (
        input  in_valid, din0, din1, out_ready,
        output in_ready, out_valid, dout
    );
    modport master (
        output in_valid, din0, din1, out_ready,
        input  in_ready, out_valid, dout
    );
`endif

endinterface

// File: rtl/transposed_fir_hls_mul_pipe_stage.sv
// rtl/transposed_fir_hls_mul_pipe_stage.sv - one valid+data pipeline register advancing on adv_i
module fir_mul_pipe_stage
    import fir_mul_pkg::*;
#(
    parameter int DW = 23
) (
    input  logic          clk_i,
    input  logic          rst_ni,
    input  logic          adv_i,
    input  stage_ctrl_t   ctrl_i,
    input  logic [DW-1:0] data_i,
    output stage_ctrl_t   ctrl_o,
    output logic [DW-1:0] data_o
);

    stage_ctrl_t   ctrl_q, ctrl_d;
    logic [DW-1:0] data_q, data_d;

    // Bubbles shift too, so an empty stage simply loads whatever sits upstream.
    always_comb begin
        ctrl_d = ctrl_q;
        data_d = data_q;
        if (adv_i) begin
            ctrl_d = ctrl_i;
            data_d = data_i;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            ctrl_q <= '0;
            data_q <= '0;
        end else begin
            ctrl_q <= ctrl_d;
            data_q <= data_d;
        end
    end

    assign ctrl_o = ctrl_q;
    assign data_o = data_q;

endmodule

// File: rtl/transposed_fir_hls_mul_pipe.sv
// rtl/transposed_fir_hls_mul_pipe.sv - pipelined sample x coefficient multiplier with Q shift and flow control
// Optional clamp-to-range output with sat_flag when FIR_MUL_PIPE_SAT_EN is defined.
module transposed_fir_hls_mul_pipe
    import fir_mul_pkg::*;
#(
    parameter int ID          = 1,
    parameter int NUM_STAGE   = 2,
    parameter int din0_WIDTH  = 16,
    parameter int din1_WIDTH  = 7,
    parameter int DIN1_SIGNED = 0,
    parameter int dout_WIDTH  = 23,
    parameter int SHIFT       = 0
) (
    input  logic                          ap_clk,
    input  logic                          ap_rst_n,
    input  logic                          ce,
    transposed_fir_hls_mul_pipe_if.slave  bus
);

    localparam int W  = prod_width(din0_WIDTH, din1_WIDTH);
    localparam int EW = (dout_WIDTH > W) ? dout_WIDTH : W;

    logic                              adv;
    logic signed [W-1:0]               a_ext, b_ext, prod, shifted;
    logic signed [EW-1:0]              s_ext;
    stage_ctrl_t                       in_ctrl;
    logic [dout_WIDTH-1:0]             in_data;
    stage_ctrl_t [NUM_STAGE:0]         ctrl;
    logic [NUM_STAGE:0][dout_WIDTH-1:0] data;

    assign adv          = ce && (!ctrl[NUM_STAGE].valid || bus.out_ready);
    assign bus.in_ready = adv;

    // The whole multiply sits in front of stage 0; retiming may spread it later.
    always_comb begin
        a_ext = W'($signed(bus.din0));
        if (DIN1_SIGNED != 0) begin
            b_ext = W'($signed(bus.din1));
        end else begin
            b_ext = W'(bus.din1);
        end
        prod    = a_ext * b_ext;
        shifted = prod >>> SHIFT;
        s_ext   = EW'(shifted);
    end

`ifdef FIR_MUL_PIPE_SAT_EN
    localparam logic [dout_WIDTH-1:0] DOUT_MAX = dout_WIDTH'(sat_max(dout_WIDTH));
    localparam logic [dout_WIDTH-1:0] DOUT_MIN = dout_WIDTH'(sat_min(dout_WIDTH));

    logic ovf;

    // Out of range when the bits above the result sign bit disagree with it.
    always_comb begin
        ovf           = (|s_ext[EW-1:dout_WIDTH-1]) && !(&s_ext[EW-1:dout_WIDTH-1]);
        in_ctrl.valid = bus.in_valid;
        in_ctrl.sat   = ovf;
        in_data       = s_ext[dout_WIDTH-1:0];
        if (ovf) begin
            in_data = s_ext[EW-1] ? DOUT_MIN : DOUT_MAX;
        end
    end

    assign bus.sat_flag = ctrl[NUM_STAGE].sat;
`else
    logic unused_bits;

    always_comb begin
        in_ctrl.valid = bus.in_valid;
        in_ctrl.sat   = 1'b0;
        in_data       = s_ext[dout_WIDTH-1:0];
    end

    assign unused_bits = ^{s_ext, ctrl[NUM_STAGE].sat};
`endif

    assign ctrl[0] = in_ctrl;
    assign data[0] = in_data;

    for (genvar g = 0; g < NUM_STAGE; g++) begin : g_stage
        fir_mul_pipe_stage #(
            .DW(dout_WIDTH)
        ) u_stage (
            .clk_i  (ap_clk),
            .rst_ni (ap_rst_n),
            .adv_i  (adv),
            .ctrl_i (ctrl[g]),
            .data_i (data[g]),
            .ctrl_o (ctrl[g+1]),
            .data_o (data[g+1])
        );
    end

    assign bus.out_valid = ctrl[NUM_STAGE].valid;
    assign bus.dout      = data[NUM_STAGE];

endmodule

// File: tb/tb_transposed_fir_hls_mul_pipe.sv
// tb/tb_transposed_fir_hls_mul_pipe.sv - randomized and directed checks of four multiplier configurations against a behavioural model
module tb_transposed_fir_hls_mul_pipe;

    logic        clk = 1'b0;
    logic        rst_n, ce, drv_valid, drv_oready;
    logic [15:0] drv_d0;
    logic [6:0]  drv_d1;
    int          n_checks = 0;
    int          n_fail   = 0;
    int          n_acc    = 0;
    int          n_ret    = 0;

`ifdef FIR_MUL_PIPE_SAT_EN
    localparam bit SAT_ON = 1'b1;
`else
    localparam bit SAT_ON = 1'b0;
`endif

    typedef struct {
        logic [15:0] a;
        logic [6:0]  b;
    } beat_t;

    beat_t sb[$];

    always #5 clk = ~clk;

    // u0 defaults, u1 signed coefficient, u2 16-bit result, u3 signed coefficient with SHIFT=1
    transposed_fir_hls_mul_pipe_if #(.din0_WIDTH(16), .din1_WIDTH(7), .dout_WIDTH(23)) if0 ();
    transposed_fir_hls_mul_pipe_if #(.din0_WIDTH(16), .din1_WIDTH(7), .dout_WIDTH(23)) if1 ();
    transposed_fir_hls_mul_pipe_if #(.din0_WIDTH(16), .din1_WIDTH(7), .dout_WIDTH(16)) if2 ();
    transposed_fir_hls_mul_pipe_if #(.din0_WIDTH(16), .din1_WIDTH(7), .dout_WIDTH(23)) if3 ();

    assign if0.in_valid = drv_valid;  assign if0.din0 = drv_d0;
    assign if0.din1 = drv_d1;         assign if0.out_ready = drv_oready;
    assign if1.in_valid = drv_valid;  assign if1.din0 = drv_d0;
    assign if1.din1 = drv_d1;         assign if1.out_ready = drv_oready;
    assign if2.in_valid = drv_valid;  assign if2.din0 = drv_d0;
    assign if2.din1 = drv_d1;         assign if2.out_ready = drv_oready;
    assign if3.in_valid = drv_valid;  assign if3.din0 = drv_d0;
    assign if3.din1 = drv_d1;         assign if3.out_ready = drv_oready;

    transposed_fir_hls_mul_pipe #(.ID(0)) u0 (
        .ap_clk(clk), .ap_rst_n(rst_n), .ce(ce), .bus(if0));
    transposed_fir_hls_mul_pipe #(.ID(1), .DIN1_SIGNED(1)) u1 (
        .ap_clk(clk), .ap_rst_n(rst_n), .ce(ce), .bus(if1));
    transposed_fir_hls_mul_pipe #(.ID(2), .dout_WIDTH(16)) u2 (
        .ap_clk(clk), .ap_rst_n(rst_n), .ce(ce), .bus(if2));
    transposed_fir_hls_mul_pipe #(.ID(3), .DIN1_SIGNED(1), .SHIFT(1)) u3 (
        .ap_clk(clk), .ap_rst_n(rst_n), .ce(ce), .bus(if3));

    task automatic check_val(input string tag, input logic signed [63:0] got,
                             input logic signed [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic longint raw_val(input logic [15:0] a, input logic [6:0] b,
                                       input bit sgn, input int sh);
        longint x, y;
        x = longint'($signed(a));
        if (sgn) y = longint'($signed(b));
        else     y = longint'({1'b0, b});
        return (x * y) >>> sh;
    endfunction

    function automatic longint hi_of(input int ow);
        return (longint'(1) <<< (ow - 1)) - 1;
    endfunction

    function automatic bit out_of_range(input longint s, input int ow);
        return (s > hi_of(ow)) || (s < -hi_of(ow) - 1);
    endfunction

    function automatic longint fit(input longint s, input int ow, input bit sat);
        longint hi, lo, m, r;
        hi = hi_of(ow);
        lo = -hi - 1;
        m  = longint'(1) <<< ow;
        if (sat) return (s > hi) ? hi : ((s < lo) ? lo : s);
        r = s & (m - 1);
        if (r > hi) r = r - m;
        return r;
    endfunction

    // Monitor: samples mid-cycle; a beat counts as accepted/retired at the following rising edge.
    initial begin
        bit          held;
        logic [22:0] held_dout;
        beat_t       b;
        held = 1'b0;
        held_dout = '0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                sb.delete();
                held = 1'b0;
            end else begin
                if (held) begin
                    check_val("hold_valid", if0.out_valid, 1);
                    check_val("hold_dout", if0.dout, held_dout);
                end
                check_val("in_ready", if0.in_ready, ce && (!if0.out_valid || drv_oready));
                held      = if0.out_valid && !(ce && drv_oready);
                held_dout = if0.dout;
                if (if0.out_valid && ce && drv_oready) begin
                    if (sb.size() == 0) begin
                        check_val("spurious_beat", 1, 0);
                    end else begin
                        b = sb.pop_front();
                        n_ret++;
                        check_val("dout_u0", $signed(if0.dout), fit(raw_val(b.a, b.b, 0, 0), 23, SAT_ON));
                        check_val("dout_u1", $signed(if1.dout), fit(raw_val(b.a, b.b, 1, 0), 23, SAT_ON));
                        check_val("dout_u2", $signed(if2.dout), fit(raw_val(b.a, b.b, 0, 0), 16, SAT_ON));
                        check_val("dout_u3", $signed(if3.dout), fit(raw_val(b.a, b.b, 1, 1), 23, SAT_ON));
`ifdef FIR_MUL_PIPE_SAT_EN
                        check_val("sat_u2", if2.sat_flag, out_of_range(raw_val(b.a, b.b, 0, 0), 16));
                        check_val("sat_u0", if0.sat_flag, out_of_range(raw_val(b.a, b.b, 0, 0), 23));
`endif
                    end
                end
                if (drv_valid && if0.in_ready) begin
                    sb.push_back('{drv_d0, drv_d1});
                    n_acc++;
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Presents one beat on an idle pipeline and returns at the mid-cycle where it is on dout.
    task automatic send_one(input logic [15:0] a, input logic [6:0] b, output int lat);
        drv_valid  = 1'b1;
        drv_d0     = a;
        drv_d1     = b;
        drv_oready = 1'b1;
        ce         = 1'b1;
        tick();
        drv_valid = 1'b0;
        lat = 0;
        for (int n = 1; n <= 20; n++) begin
            @(negedge clk);
            if (if0.out_valid) begin
                lat = n;
                break;
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1);
    end

    initial begin
        int lat, a0, r0, cyc, stalls, k;
        rst_n = 1'b0; ce = 1'b0; drv_valid = 1'b0; drv_oready = 1'b0;
        drv_d0 = '0;  drv_d1 = '0;
        repeat (2) @(negedge clk);
        check_val("rst_out_valid", if0.out_valid, 0);
        check_val("rst_dout", if0.dout, 0);
        check_val("rst_in_ready", if0.in_ready, 0);
        tick();
        rst_n = 1'b1; ce = 1'b1; drv_oready = 1'b1;
        repeat (2) tick();

        send_one(16'd3, 7'd5, lat);
        check_val("lat_cycles", lat, 2);
        check_val("lat_dout", $signed(if0.dout), 15);
        @(negedge clk);
        check_val("lat_bubble", if0.out_valid, 0);
        tick();

        send_one(16'h8000, 7'd127, lat);
        check_val("ext_dout", $signed(if0.dout), -4161536);
        tick();

        send_one(16'd100, 7'h7F, lat);
        check_val("unsigned_coef", $signed(if0.dout), 12700);
        check_val("signed_coef", $signed(if1.dout), -100);
        tick();

        send_one(16'hFFFD, 7'd1, lat);
        check_val("shift_floor", $signed(if3.dout), -2);
        tick();

        send_one(16'd1000, 7'd100, lat);
        check_val("sat_dout", $signed(if2.dout), SAT_ON ? 32767 : -31072);
`ifdef FIR_MUL_PIPE_SAT_EN
        check_val("sat_flag", if2.sat_flag, 1);
`endif
        tick();

        a0 = n_acc; r0 = n_ret;
        for (int i = 0; i < 100; i++) begin
            drv_valid = 1'b1;
            drv_d0    = 16'($urandom);
            drv_d1    = 7'($urandom);
            tick();
        end
        drv_valid = 1'b0;
        repeat (4) tick();
        check_val("stream_accepts", n_acc - a0, 100);
        check_val("stream_delivered", n_ret - r0, 100);

        a0 = n_acc; r0 = n_ret; cyc = 0; stalls = 0;
        drv_d0 = 16'($urandom);
        drv_d1 = 7'($urandom);
        while ((n_acc - a0) < 8 && cyc < 60) begin
            drv_valid  = 1'b1;
            drv_oready = !(cyc >= 4 && cyc <= 6);
            ce         = !(cyc == 7 || cyc == 8);
            k = n_acc - a0;
            @(negedge clk);
            if (!if0.in_ready) stalls++;
            tick();
            cyc++;
            if ((n_acc - a0) != k) begin
                drv_d0 = 16'($urandom);
                drv_d1 = 7'($urandom);
            end
        end
        drv_valid = 1'b0; drv_oready = 1'b1; ce = 1'b1;
        repeat (5) tick();
        check_val("bp_stall_cycles", stalls, 5);
        check_val("bp_delivered", n_ret - r0, 8);

        drv_valid = 1'b1;
        drv_d0 = 16'($urandom); drv_d1 = 7'($urandom);
        tick();
        drv_d0 = 16'($urandom); drv_d1 = 7'($urandom);
        tick();
        drv_valid = 1'b0;
        #1;
        check_val("rst_pre_valid", if0.out_valid, 1);
        rst_n = 1'b0;
        #1;
        check_val("rst_async_valid", if0.out_valid, 0);
        check_val("rst_async_valid_u3", if3.out_valid, 0);
        check_val("rst_async_dout", if0.dout, 0);
        repeat (2) @(negedge clk);
        tick();
        rst_n = 1'b1;
        tick();
        r0 = n_ret;
        send_one(16'd7, 7'd7, lat);
        check_val("post_rst_lat", lat, 2);
        check_val("post_rst_u0", $signed(if0.dout), 49);
        check_val("post_rst_u2", $signed(if2.dout), 49);
        check_val("post_rst_u3", $signed(if3.dout), 24);
        tick();
        repeat (6) tick();
        check_val("post_rst_beats", n_ret - r0, 1);
        check_val("sb_empty", sb.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
